control_unit_fsm: RTL and testbench

CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

---
 rtl/mini_risc_pkg.sv | 84 ++++++++
 rtl/control_unit_fsm.sv | 165 ++++++++++++++++
 tb/tb_control_unit_fsm.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mini_risc_pkg.sv
// ============================================================================
// Module      : mini_risc_pkg
// Description : Shared encodings for the mini-RISC control unit and data path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mini_risc_pkg;

  // FSM state encoding
  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_FETCH  = 3'd1;
  localparam logic [2:0] C_ST_DECODE = 3'd2;
  localparam logic [2:0] C_ST_EXEC   = 3'd3;
  localparam logic [2:0] C_ST_MEM    = 3'd4;
  localparam logic [2:0] C_ST_WB     = 3'd5;
  localparam logic [2:0] C_ST_HALT   = 3'd6;

  localparam logic [5:0] C_OP_RTYPE  = 6'd0;
  localparam logic [5:0] C_OP_ADDI   = 6'd1;
  localparam logic [5:0] C_OP_COMPI  = 6'd2;
  localparam logic [5:0] C_OP_LW     = 6'd3;
  localparam logic [5:0] C_OP_SW     = 6'd4;
  localparam logic [5:0] C_OP_BRANCH = 6'd5;
  localparam logic [5:0] C_OP_HALT   = 6'd63;

  localparam logic [5:0] C_FN_ADD    = 6'd0;
  localparam logic [5:0] C_FN_COMP   = 6'd1;
  localparam logic [5:0] C_FN_AND    = 6'd2;
  localparam logic [5:0] C_FN_XOR    = 6'd3;
  localparam logic [5:0] C_FN_SHLL   = 6'd4;
  localparam logic [5:0] C_FN_SHRL   = 6'd5;
  localparam logic [5:0] C_FN_SHLLV  = 6'd6;
  localparam logic [5:0] C_FN_SHRLV  = 6'd7;
  localparam logic [5:0] C_FN_SHRA   = 6'd8;
  localparam logic [5:0] C_FN_SHRAV  = 6'd9;

  localparam logic [3:0] C_ALU_ADD   = 4'd0;
  localparam logic [3:0] C_ALU_COMP  = 4'd1;

  localparam logic [4:0] C_BR_NONE   = 5'd0;
  localparam logic [4:0] C_BR_B      = 5'd1;
  localparam logic [4:0] C_BR_BR     = 5'd2;
  localparam logic [4:0] C_BR_BLTZ   = 5'd3;
  localparam logic [4:0] C_BR_BZ     = 5'd4;
  localparam logic [4:0] C_BR_BNZ    = 5'd5;
  localparam logic [4:0] C_BR_BL     = 5'd6;
  localparam logic [4:0] C_BR_BCY    = 5'd7;
  localparam logic [4:0] C_BR_BNCY   = 5'd8;

  localparam logic [1:0] C_RW_NONE   = 2'b00;
  localparam logic [1:0] C_RW_RS     = 2'b01;
  localparam logic [1:0] C_RW_R31    = 2'b10;

  localparam logic [1:0] C_WB_DMEM   = 2'b00;
  localparam logic [1:0] C_WB_PC4    = 2'b01;
  localparam logic [1:0] C_WB_ALU    = 2'b10;

  localparam logic C_IMM_SEXT   = 1'b0;
  localparam logic C_IMM_SHAMT  = 1'b1;
  localparam logic C_ALUSRC_REG = 1'b0;
  localparam logic C_ALUSRC_IMM = 1'b1;

  // Halt counts as legal; it is the only legal opcode that never reaches EXEC.
  function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      C_OP_RTYPE:  ok = (fn <= C_FN_SHRAV);
      C_OP_ADDI, C_OP_COMPI, C_OP_LW, C_OP_SW, C_OP_HALT: ok = 1'b1;
      C_OP_BRANCH: ok = (fn >= 6'd1) && (fn <= 6'd8);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Immediate-shift R-type ops take their second operand from the shamt field.
  function automatic logic uses_shamt(input logic [5:0] fn);
    return (fn == C_FN_SHLL) || (fn == C_FN_SHRL) || (fn == C_FN_SHRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_fsm.sv
// ============================================================================
// Module      : control_unit_fsm
// Description : Multi-cycle mini-RISC control FSM with retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit_fsm
  import mini_risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  reg_write,
  output logic        imm_mux_ctrl,
  output logic        alu_mux_ctrl,
  output logic [3:0]  alu_op,
  output logic        dmem_enable,
  output logic        dmem_write_enable,
  output logic [1:0]  reg_write_mux_ctrl,
  output logic [4:0]  br_op,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  logic [2:0]  r_state_q,   w_state_d;
  logic [5:0]  r_opcode_q,  w_opcode_d;
  logic [5:0]  r_func_q,    w_func_d;
  logic        r_illegal_q, w_illegal_d;
  logic [31:0] r_retired_q, w_retired_d;

  logic w_is_rtype;
  logic w_is_compi;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_branch;
  logic w_done;

  always_comb begin
    w_is_rtype  = (r_opcode_q == C_OP_RTYPE);
    w_is_compi  = (r_opcode_q == C_OP_COMPI);
    w_is_lw     = (r_opcode_q == C_OP_LW);
    w_is_sw     = (r_opcode_q == C_OP_SW);
    w_is_branch = (r_opcode_q == C_OP_BRANCH);
  end

  // Legality must be judged on the live inputs: the latched copy lands on this same edge.
  always_comb begin
    w_state_d   = r_state_q;
    w_opcode_d  = r_opcode_q;
    w_func_d    = r_func_q;
    w_illegal_d = r_illegal_q;
    case (r_state_q)
      C_ST_IDLE:   w_state_d = C_ST_FETCH;
      C_ST_FETCH:  w_state_d = C_ST_DECODE;
      C_ST_DECODE: begin
        w_opcode_d = opcode;
        w_func_d   = func;
        if (!insn_legal(opcode, func)) begin
          w_illegal_d = 1'b1;
          w_state_d   = C_ST_HALT;
        end else if (opcode == C_OP_HALT) begin
          w_state_d   = C_ST_HALT;
        end else begin
          w_state_d   = C_ST_EXEC;
        end
      end
      C_ST_EXEC: begin
        if (w_is_branch)             w_state_d = C_ST_FETCH;
        else if (w_is_lw || w_is_sw) w_state_d = C_ST_MEM;
        else                         w_state_d = C_ST_WB;
      end
      C_ST_MEM:  w_state_d = w_is_lw ? C_ST_WB : C_ST_FETCH;
      C_ST_WB:   w_state_d = C_ST_FETCH;
      C_ST_HALT: w_state_d = C_ST_HALT;
      default:   w_state_d = C_ST_IDLE;
    endcase
  end

  always_comb begin
    w_done = (r_state_q == C_ST_WB)
           || ((r_state_q == C_ST_MEM)  && w_is_sw)
           || ((r_state_q == C_ST_EXEC) && w_is_branch);
    w_retired_d = r_retired_q + {31'd0, w_done};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q   <= C_ST_IDLE;
      r_opcode_q  <= 6'd0;
      r_func_q    <= 6'd0;
      r_illegal_q <= 1'b0;
      r_retired_q <= 32'd0;
    end else begin
      r_state_q   <= w_state_d;
      r_opcode_q  <= w_opcode_d;
      r_func_q    <= w_func_d;
      r_illegal_q <= w_illegal_d;
      r_retired_q <= w_retired_d;
    end
  end

  always_comb begin
    ir_en              = 1'b0;
    pc_en              = 1'b0;
    reg_write          = C_RW_NONE;
    imm_mux_ctrl       = C_IMM_SEXT;
    alu_mux_ctrl       = C_ALUSRC_REG;
    alu_op             = C_ALU_ADD;
    dmem_enable        = 1'b0;
    dmem_write_enable  = 1'b0;
    reg_write_mux_ctrl = C_WB_DMEM;
    br_op              = C_BR_NONE;

    // ALU selects stay stable from EXEC to the final state so the result holds through WB.
    if (((r_state_q == C_ST_EXEC) || (r_state_q == C_ST_MEM) || (r_state_q == C_ST_WB))
        && !w_is_branch) begin
      if (w_is_rtype) begin
        alu_op       = r_func_q[3:0];
        imm_mux_ctrl = uses_shamt(r_func_q) ? C_IMM_SHAMT  : C_IMM_SEXT;
        alu_mux_ctrl = uses_shamt(r_func_q) ? C_ALUSRC_IMM : C_ALUSRC_REG;
      end else begin
        alu_op       = w_is_compi ? C_ALU_COMP : C_ALU_ADD;
        imm_mux_ctrl = C_IMM_SEXT;
        alu_mux_ctrl = C_ALUSRC_IMM;
      end
    end

    case (r_state_q)
      C_ST_FETCH: ir_en = 1'b1;
      C_ST_EXEC: begin
        if (w_is_branch) begin
          br_op = r_func_q[4:0];
          pc_en = 1'b1;
          if (r_func_q[4:0] == C_BR_BL) begin
            reg_write          = C_RW_R31;
            reg_write_mux_ctrl = C_WB_PC4;
          end
        end
      end
      C_ST_MEM: begin
        dmem_enable       = w_is_lw || w_is_sw;
        dmem_write_enable = w_is_sw;
        pc_en             = w_is_sw;
      end
      C_ST_WB: begin
        pc_en              = 1'b1;
        reg_write          = C_RW_RS;
        reg_write_mux_ctrl = w_is_lw ? C_WB_DMEM : C_WB_ALU;
      end
      default: ;
    endcase
  end

  assign halted  = (r_state_q == C_ST_HALT);
  assign illegal = r_illegal_q;
  assign retired = r_retired_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit_fsm.sv
// ============================================================================
// Module      : tb_control_unit_fsm
// Description : Table-driven self-checking bench for control_unit_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit_fsm;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        ir_en;
  logic        pc_en;
  logic [1:0]  reg_write;
  logic        imm_mux_ctrl;
  logic        alu_mux_ctrl;
  logic [3:0]  alu_op;
  logic        dmem_enable;
  logic        dmem_write_enable;
  logic [1:0]  reg_write_mux_ctrl;
  logic [4:0]  br_op;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  control_unit_fsm dut (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .func               (func),
    .ir_en              (ir_en),
    .pc_en              (pc_en),
    .reg_write          (reg_write),
    .imm_mux_ctrl       (imm_mux_ctrl),
    .alu_mux_ctrl       (alu_mux_ctrl),
    .alu_op             (alu_op),
    .dmem_enable        (dmem_enable),
    .dmem_write_enable  (dmem_write_enable),
    .reg_write_mux_ctrl (reg_write_mux_ctrl),
    .br_op              (br_op),
    .halted             (halted),
    .illegal            (illegal),
    .retired            (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    logic       amux;
    logic       imux;
    logic [1:0] wmux;
    logic [4:0] br;
    logic [1:0] brw;
  } vec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       exp_ill;
  } ill_t;

  vec_t        vecs [12];
  ill_t        ills [6];
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_retired;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // {ir_en, pc_en, reg_write, imm, alu_mux, alu_op, dmem_en, dmem_we, wb_mux, br_op}
  function automatic logic [18:0] ctrl_vec(input logic ir, input logic pc, input logic [1:0] rw,
                                           input logic imm, input logic amux, input logic [3:0] alu,
                                           input logic den, input logic dwe, input logic [1:0] wm,
                                           input logic [4:0] br);
    return {ir, pc, rw, imm, amux, alu, den, dwe, wm, br};
  endfunction

  function automatic logic [31:0] act_ctrl();
    return {13'd0, ir_en, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
            dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op};
  endfunction

  function automatic logic [31:0] exp32(input logic [18:0] c);
    return {13'd0, c};
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_retired = 32'd0;
  endtask

  // Entered with the DUT in FETCH; leaves it in the FETCH of the next instruction.
  task automatic run_vec(input vec_t v);
    logic is_lw, is_sw, is_br;
    logic [31:0] r0;
    is_lw = (v.op == 6'd3);
    is_sw = (v.op == 6'd4);
    is_br = (v.op == 6'd5);
    r0    = exp_retired;
    opcode = v.op;
    func   = v.fn;
    check({v.name, " FETCH"}, act_ctrl(), exp32(ctrl_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step();
    check({v.name, " DECODE"}, act_ctrl(), exp32(ctrl_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step();
    // Scramble inputs: from here on only the latched copy may matter.
    opcode = 6'h3E;
    func   = 6'h3F;
    if (is_br)
      check({v.name, " EXEC"}, act_ctrl(),
            exp32(ctrl_vec(0, 1, v.brw, 0, 0, 0, 0, 0, (v.brw != 2'b00) ? 2'b01 : 2'b00, v.br)));
    else
      check({v.name, " EXEC"}, act_ctrl(),
            exp32(ctrl_vec(0, 0, 0, v.imux, v.amux, v.alu, 0, 0, 0, 0)));
    if (is_lw || is_sw) begin
      step();
      check({v.name, " MEM"}, act_ctrl(),
            exp32(ctrl_vec(0, is_sw, 0, v.imux, v.amux, v.alu, 1, is_sw, 0, 0)));
    end
    if (!is_br && !is_sw) begin
      step();
      check({v.name, " WB"}, act_ctrl(),
            exp32(ctrl_vec(0, 1, 2'b01, v.imux, v.amux, v.alu, 0, 0, v.wmux, 0)));
    end
    check({v.name, " retired before final edge"}, retired, r0);
    step();
    exp_retired = r0 + 32'd1;
    check({v.name, " retired"}, retired, exp_retired);
    check({v.name, " back to FETCH"}, {31'd0, ir_en}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    opcode   = 6'd0;
    func     = 6'd0;
    exp_retired = 32'd0;

    //           name     op     fn     alu   amux  imux  wmux   br    brw
    vecs[0]  = '{"xor",   6'd0, 6'd3,  4'd3, 1'b0, 1'b0, 2'b10, 5'd0, 2'b00};
    vecs[1]  = '{"add",   6'd0, 6'd0,  4'd0, 1'b0, 1'b0, 2'b10, 5'd0, 2'b00};
    vecs[2]  = '{"shll",  6'd0, 6'd4,  4'd4, 1'b1, 1'b1, 2'b10, 5'd0, 2'b00};
    vecs[3]  = '{"shra",  6'd0, 6'd8,  4'd8, 1'b1, 1'b1, 2'b10, 5'd0, 2'b00};
    vecs[4]  = '{"shrav", 6'd0, 6'd9,  4'd9, 1'b0, 1'b0, 2'b10, 5'd0, 2'b00};
    vecs[5]  = '{"addi",  6'd1, 6'd17, 4'd0, 1'b1, 1'b0, 2'b10, 5'd0, 2'b00};
    vecs[6]  = '{"compi", 6'd2, 6'd0,  4'd1, 1'b1, 1'b0, 2'b10, 5'd0, 2'b00};
    vecs[7]  = '{"lw",    6'd3, 6'd0,  4'd0, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00};
    vecs[8]  = '{"sw",    6'd4, 6'd0,  4'd0, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00};
    vecs[9]  = '{"b",     6'd5, 6'd1,  4'd0, 1'b0, 1'b0, 2'b00, 5'd1, 2'b00};
    vecs[10] = '{"bl",    6'd5, 6'd6,  4'd0, 1'b0, 1'b0, 2'b00, 5'd6, 2'b10};
    vecs[11] = '{"bncy",  6'd5, 6'd8,  4'd0, 1'b0, 1'b0, 2'b00, 5'd8, 2'b00};

    ills[0] = '{6'd7,  6'd0,  1'b1};
    ills[1] = '{6'd0,  6'd10, 1'b1};
    ills[2] = '{6'd5,  6'd0,  1'b1};
    ills[3] = '{6'd5,  6'd9,  1'b1};
    ills[4] = '{6'd6,  6'd0,  1'b1};
    ills[5] = '{6'd63, 6'd0,  1'b0};

    // Reset state
    step();
    step();
    check("reset controls", act_ctrl(), 32'd0);
    check("reset retired", retired, 32'd0);
    check("reset halted", {31'd0, halted}, 32'd0);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Illegal opcode 7 after a run: retired must not move and HALT must stick.
    opcode = 6'd7;
    func   = 6'd0;
    step();
    check("illegal still clear in DECODE", {31'd0, illegal}, 32'd0);
    step();
    for (int c = 0; c < 10; c++) begin
      check("op7 HALT controls", act_ctrl(), 32'd0);
      check("op7 halted", {31'd0, halted}, 32'd1);
      check("op7 illegal", {31'd0, illegal}, 32'd1);
      check("op7 retired", retired, exp_retired);
      step();
    end

    // Reset asserted in the MEM cycle of a store
    reset_dut();
    step();
    run_vec(vecs[0]);
    opcode = 6'd4;
    func   = 6'd0;
    step();
    step();
    step();
    check("sw MEM write enable", {31'd0, dmem_write_enable}, 32'd1);
    rst = 1'b1;
    step();
    check("mid-sw reset controls", act_ctrl(), 32'd0);
    check("mid-sw reset retired", retired, 32'd0);
    rst = 1'b0;
    step();
    check("post-reset FETCH", {31'd0, ir_en}, 32'd1);

    // Illegal encodings and halt, each from a fresh reset
    for (int i = 0; i < 6; i++) begin
      reset_dut();
      step();
      opcode = ills[i].op;
      func   = ills[i].fn;
      step();
      step();
      check($sformatf("halt case %0d halted", i), {31'd0, halted}, 32'd1);
      check($sformatf("halt case %0d illegal", i), {31'd0, illegal}, {31'd0, ills[i].exp_ill});
      check($sformatf("halt case %0d controls", i), act_ctrl(), 32'd0);
      step();
      step();
      check($sformatf("halt case %0d stays", i), {31'd0, halted}, 32'd1);
    end

    // Counter wrap: preload 2^32-1 during the IDLE cycle, then retire one addi
    reset_dut();
    force dut.w_retired_d = 32'hFFFF_FFFF;
    step();
    release dut.w_retired_d;
    check("preload retired", retired, 32'hFFFF_FFFF);
    exp_retired = 32'hFFFF_FFFF;
    run_vec(vecs[5]);
    check("retired wrapped", retired, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
